// File: rtl/music_sequencer.sv
// ---------------------------------------------------------------------------
// music_sequencer
//
// Player-side driver for the note-length/note-change interface. Walks a song
// stored in an external synchronous ROM (one byte per note), presents each
// note's length code and pitch, and advances to the next note every time the
// music timer pulses note_change. Playback ends at an end-marker byte or at
// the last valid ROM address.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   play         start pulse, honoured only when idle or finished
//   stop         abort playback, overrides every other input
//   note_change  one-cycle pulse from the timer at the end of a note
//   rom_addr     song ROM read address
//   rom_data     ROM word, [7:4] length code, [3:0] pitch, one cycle latency
//   length       length code to the timer (0 = none)
//   pitch        pitch index to the tone generator (0 = rest)
//   playing      high while a song is being fetched or played
//   song_done    one-cycle pulse when the end of the song is reached
//
// Optional feature macro: MUSIC_SEQ_LOOP_EN
//   When defined the song restarts from address 0 instead of finishing,
//   except for an end marker at address 0, which would otherwise loop
//   forever in silence.
// ---------------------------------------------------------------------------
module music_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int SONG_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              note_change,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        length,
    output logic [3:0]        pitch,
    output logic              playing,
    output logic              song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LATCH,
        PLAY,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [3:0]        length_nxt;
    logic [3:0]        pitch_nxt;
    logic              playing_nxt;
    logic              done_nxt;
    logic              rom_is_note;

    // Only length codes 1..7 are real notes. Code 0 and the reserved codes
    // 8..15 never let the timer advance, so they all act as end markers.
    assign rom_is_note = (rom_data[7] == 1'b0) && (rom_data[6:4] != 3'd0);

    // Next-state and next-output logic. Every output is registered, so this
    // block decides what each register holds after the coming edge. Stop is
    // checked before the state decode so it beats play, note_change and an
    // end marker arriving in the same cycle. Length is dropped to zero on
    // every note boundary so the timer restarts its count for each note.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = rom_addr;
        length_nxt = length;
        pitch_nxt  = pitch;
        done_nxt   = 1'b0;

        if (stop) begin
            state_nxt  = IDLE;
            addr_nxt   = '0;
            length_nxt = 4'd0;
            pitch_nxt  = 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    length_nxt = 4'd0;
                    pitch_nxt  = 4'd0;
                    if (play) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    length_nxt = 4'd0;
                    state_nxt  = WAIT;
                end
                WAIT: begin
                    state_nxt = LATCH;
                end
                LATCH: begin
                    if (rom_is_note) begin
                        length_nxt = rom_data[7:4];
                        pitch_nxt  = rom_data[3:0];
                        state_nxt  = PLAY;
                    end else begin
                        length_nxt = 4'd0;
                        pitch_nxt  = 4'd0;
                        done_nxt   = 1'b1;
`ifdef MUSIC_SEQ_LOOP_EN
                        if (rom_addr != '0) begin
                            state_nxt = FETCH;
                            addr_nxt  = '0;
                        end else begin
                            state_nxt = DONE;
                        end
`else
                        state_nxt = DONE;
`endif
                    end
                end
                PLAY: begin
                    if (note_change) begin
                        length_nxt = 4'd0;
                        if (rom_addr < LAST_ADDR) begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = FETCH;
                        end else begin
                            pitch_nxt = 4'd0;
                            done_nxt  = 1'b1;
`ifdef MUSIC_SEQ_LOOP_EN
                            addr_nxt  = '0;
                            state_nxt = FETCH;
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    addr_nxt   = '0;
                    length_nxt = 4'd0;
                    pitch_nxt  = 4'd0;
                end
            endcase
        end

        playing_nxt = (state_nxt == FETCH) || (state_nxt == WAIT) ||
                      (state_nxt == LATCH) || (state_nxt == PLAY);
    end

    // State and output registers. Reset puts everything back to a silent
    // idle sequencer; a reset mid-note shows the timer length 0, which
    // clears the timer as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            length    <= 4'd0;
            pitch     <= 4'd0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            length    <= length_nxt;
            pitch     <= pitch_nxt;
            playing   <= playing_nxt;
            song_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// ---------------------------------------------------------------------------
// tb_music_sequencer
//
// Scoreboard bench for music_sequencer. The driver issues play, note_change,
// stop and reset, and for each accepted stimulus a song-level model predicts
// the next visible event (a note starting, or the song_done pulse) together
// with the cycle it must appear on. A separate monitor watches the DUT,
// turns note starts and song_done pulses into events and checks them against
// the queue.
// ---------------------------------------------------------------------------
module tb_music_sequencer;

    localparam int ADDR_W   = 3;
    localparam int SONG_LEN = 4;
    localparam int ROM_SIZE = 2 ** ADDR_W;

    typedef enum int {M_IDLE, M_PLAY, M_DONE} mstate_t;

    typedef struct {
        bit is_done;
        int addr;
        int len;
        int pit;
        int cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              play;
    logic              stop;
    logic              note_change;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [3:0]        length;
    logic [3:0]        pitch;
    logic              playing;
    logic              song_done;

    logic [7:0] rom [ROM_SIZE];

    int      cyc = 0;
    int      vectors = 0;
    int      miscompares = 0;
    exp_t    sb[$];
    mstate_t m_state = M_IDLE;
    int      m_addr = 0;
    int      m_busy_until = 0;
    logic [3:0] prev_len = 4'd0;
    logic [3:0] prev_pitch = 4'd0;
    logic       prev_done = 1'b0;

    music_sequencer #(
        .ADDR_W   (ADDR_W),
        .SONG_LEN (SONG_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .play        (play),
        .stop        (stop),
        .note_change (note_change),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .length      (length),
        .pitch       (pitch),
        .playing     (playing),
        .song_done   (song_done)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time-stamp expected and observed events.
    always @(posedge clk) begin
        cyc = cyc + 1;
    end

    // Synchronous song ROM with one cycle of read latency.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model of the song: what the sequencer must show for ROM address a.
    task automatic pushLookup(input int a, input int at_cyc);
        exp_t e;
        int   code;
        code   = int'(rom[a][7:4]);
        e.addr = a;
        e.cyc  = at_cyc;
        if (code >= 1 && code <= 7) begin
            e.is_done = 1'b0;
            e.len     = code;
            e.pit     = int'(rom[a][3:0]);
            m_state   = M_PLAY;
        end else begin
            e.is_done = 1'b1;
            e.len     = 0;
            e.pit     = 0;
            m_state   = M_DONE;
        end
        m_busy_until = at_cyc;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then update the model. Inputs set while at
    // edge k are sampled at edge k+1; a newly fetched note is visible after
    // edge k+4, the last-address song_done after edge k+1.
    task automatic applyStimulus(input bit p, input bit nc, input bit st, input bit rs);
        int   k;
        exp_t keep[$];
        exp_t e;
        play        = p;
        note_change = nc;
        stop        = st;
        rst         = rs;
        k           = cyc;
        tick();
        play        = 1'b0;
        note_change = 1'b0;
        stop        = 1'b0;
        rst         = 1'b0;

        if (rs || st) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].cyc <= k) keep.push_back(sb[i]);
            end
            sb           = keep;
            m_state      = M_IDLE;
            m_addr       = 0;
            m_busy_until = 0;
        end else if (k < m_busy_until) begin
            // note is still being fetched: play and note_change have no effect
        end else if (p && (m_state == M_IDLE || m_state == M_DONE)) begin
            m_addr = 0;
            pushLookup(0, k + 4);
        end else if (nc && m_state == M_PLAY) begin
            if (m_addr == SONG_LEN - 1) begin
                e.is_done    = 1'b1;
                e.addr       = m_addr;
                e.len        = 0;
                e.pit        = 0;
                e.cyc        = k + 1;
                sb.push_back(e);
                m_state      = M_DONE;
                m_busy_until = k + 1;
            end else begin
                m_addr = m_addr + 1;
                pushLookup(m_addr, k + 4);
            end
        end
    endtask

    task automatic waitReady();
        int guard = 0;
        while (cyc < m_busy_until && guard < 20) begin
            tick();
            guard++;
        end
    endtask

    // Let pending events drain, then check the resting outputs.
    task automatic finishSong();
        waitReady();
        tick();
        tick();
        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("rest_length", 32'(length), 0);
        checkOutput("rest_pitch", 32'(pitch), 0);
        checkOutput("rest_playing", 32'(playing), 0);
        checkOutput("rest_song_done", 32'(song_done), 0);
        if (m_state == M_DONE)
            checkOutput("done_addr_held", 32'(rom_addr), m_addr);
        else
            checkOutput("idle_addr", 32'(rom_addr), 0);
    endtask

    task automatic runSong(input bit rnd);
        int n = 0;
        int r;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        while (m_state == M_PLAY && n < 3 * SONG_LEN) begin
            waitReady();
            if (rnd) begin
                for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                    applyStimulus($urandom_range(0, 5) == 0, 1'b0, 1'b0, 1'b0);
                r = int'($urandom_range(0, 99));
                if (r < 5) begin
                    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
                end else if (r < 8) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
                end else begin
                    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                    if ($urandom_range(0, 3) == 0)
                        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                end
            end else begin
                tick();
                tick();
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            end
            n++;
        end
        finishSong();
    endtask

    task automatic fillRom(input logic [7:0] val);
        for (int a = 0; a < ROM_SIZE; a++) rom[a] = val;
    endtask

    // Monitor: converts DUT activity into events and compares them with the
    // scoreboard, and checks that a sounding note holds steady.
    task automatic observe(input bit kind);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_event: got done=%0d addr=%0d len=%0d pitch=%0d at cycle %0d, expected no event",
                     kind, rom_addr, length, pitch, cyc);
        end else begin
            e = sb.pop_front();
            checkOutput("event_fields",
                        32'({kind, 8'(rom_addr), length, pitch, playing}),
                        32'({e.is_done, 8'(e.addr), 4'(e.len), 4'(e.pit), !e.is_done}));
            checkOutput("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (length != 4'd0 && prev_len != 4'd0)
            checkOutput("note_hold", 32'({length, pitch}), 32'({prev_len, prev_pitch}));
        if (length != 4'd0 && prev_len == 4'd0)
            observe(1'b0);
        if (song_done) begin
            checkOutput("done_single_cycle", 32'(prev_done), 0);
            observe(1'b1);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missed_event: got nothing by cycle %0d, expected done=%0d addr=%0d len=%0d at cycle %0d",
                     cyc, sb[0].is_done, sb[0].addr, sb[0].len, sb[0].cyc);
            void'(sb.pop_front());
        end
        prev_len   = length;
        prev_pitch = pitch;
        prev_done  = song_done;
    end

    // Directed scenarios first, then randomized songs.
    initial begin
        rst         = 1'b1;
        play        = 1'b0;
        stop        = 1'b0;
        note_change = 1'b0;
        fillRom(8'h00);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_addr", 32'(rom_addr), 0);
        checkOutput("reset_length", 32'(length), 0);
        checkOutput("reset_pitch", 32'(pitch), 0);
        checkOutput("reset_playing", 32'(playing), 0);
        checkOutput("reset_song_done", 32'(song_done), 0);

        $display("[TB] two notes then end marker");
        fillRom(8'h00);
        rom[0] = 8'h35;
        rom[1] = 8'h27;
        rom[2] = 8'h00;
        runSong(1'b0);

        $display("[TB] full song to last address");
        fillRom(8'h41);
        runSong(1'b0);

        $display("[TB] stop with note_change in same cycle");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitReady();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        finishSong();

        $display("[TB] play ignored during note");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitReady();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitReady();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("play_ignored_addr", 32'(rom_addr), 1);
        checkOutput("play_ignored_length", 32'(length), 4);
        checkOutput("play_ignored_pitch", 32'(pitch), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        finishSong();

        $display("[TB] reserved code at address 0");
        fillRom(8'h41);
        rom[0] = 8'h9A;
        runSong(1'b0);

        $display("[TB] reset mid-note");
        fillRom(8'h63);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitReady();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        finishSong();

        $display("[TB] randomized songs");
        for (int s = 0; s < 60; s++) begin
            for (int a = 0; a < ROM_SIZE; a++) begin
                if ($urandom_range(0, 99) < 15) begin
                    int x;
                    x = int'($urandom_range(0, 8));
                    rom[a] = {4'((x == 0) ? 0 : x + 7), 4'($urandom_range(0, 15))};
                end else begin
                    rom[a] = {4'($urandom_range(1, 7)), 4'($urandom_range(0, 15))};
                end
            end
            runSong(1'b1);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            finishSong();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #2000000;
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion by time limit, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Drives the note-length/note-change interface from the player side, the opposite end from music_timer.
- Reads a song from an external synchronous ROM, one byte per note.
- Presents each note's length code and pitch to the timer and tone generator.
- Advances to the next note on each note_change pulse from music_timer; stops at an end marker or the last address.

Parameters:
- ADDR_W, 6, song ROM address width.
- SONG_LEN, 64, number of valid ROM entries; 1..2^ADDR_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- play  input  1  start pulse; honoured only in IDLE or DONE.
- stop  input  1  abort playback; wins over every other input.
- note_change  input  1  one-cycle pulse from music_timer marking the end of the current note.
- rom_addr  output  ADDR_W  song ROM read address.
- rom_data  input  8  ROM word: [7:4] length code, [3:0] pitch. Valid exactly one cycle after rom_addr.
- length  output  4  length code to music_timer: 0 none, 1 whole, 2 half, 3 quarter, 4 eighth, 5 dotted half, 6 dotted quarter, 7 dotted eighth.
- pitch  output  4  pitch index to the tone generator; 0 = rest.
- playing  output  1  high in FETCH, WAIT, LATCH and PLAY.
- song_done  output  1  one-cycle pulse when the end of the song is reached.

Behaviour:
- Reset (clk edge with rst=1), all registered:
  - state=IDLE, rom_addr=0, length=0, pitch=0, playing=0, song_done=0.
- States: IDLE, FETCH, WAIT, LATCH, PLAY, DONE.
- IDLE: length=0, pitch=0. play=1 -> FETCH with rom_addr=0.
- FETCH: rom_addr held; length forced to 0, which clears the timer's counter so every note starts from count 0. -> WAIT.
- WAIT: ROM access cycle. -> LATCH.
- LATCH: sample rom_data.
  - rom_data[7:4] in 1..7: length<=[7:4], pitch<=[3:0]; -> PLAY.
  - rom_data[7:4] = 0 or 8..15: end marker (the timer never advances on these codes); -> DONE, song_done=1 for that cycle.
- Latency: 3 cycles from play accepted to length valid, i.e. play sampled at edge N gives length nonzero after edge N+3.
- PLAY: hold length and pitch.
  - note_change=1 and rom_addr < SONG_LEN-1: rom_addr<=rom_addr+1, length<=0, -> FETCH.
  - note_change=1 and rom_addr = SONG_LEN-1: length<=0, pitch<=0, song_done pulse, -> DONE. No wrap-around.
- Note-to-note gap: 3 cycles with length=0 (FETCH, WAIT, LATCH).
- DONE: length=0, pitch=0, playing=0, rom_addr held. play=1 -> FETCH with rom_addr=0.
- play in any state other than IDLE/DONE: ignored, no restart.
- stop=1 in any state: next edge -> IDLE, rom_addr=0, length=0, pitch=0. No song_done pulse. stop beats play, note_change and the end marker in the same cycle.
- note_change outside PLAY: ignored.
- rst mid-note: same as reset; the timer sees length=0 and clears itself.
- song_done never asserts for more than one consecutive cycle.

Optional Feature:
- Macro: MUSIC_SEQ_LOOP_EN.
- Defined:
  - An end marker or note_change at SONG_LEN-1 still pulses song_done.
  - The block then goes to FETCH with rom_addr=0 instead of DONE; playing stays 1; the song repeats until stop.
  - Exception: an end marker at address 0 goes to DONE, preventing an endless silent loop.
- Undefined: behaviour exactly as above; DONE is terminal until play.

Test Plan:
- ROM[0]=0x35, ROM[1]=0x27, ROM[2]=0x00. Pulse play.
  -> length=3/pitch=5 three cycles later.
  -> note_change gives length=0 for 3 cycles, then length=2/pitch=7.
  -> next note_change gives song_done pulse at rom_addr=2, DONE, length=0.
- SONG_LEN=4, ROM all 0x41, four note_change pulses.
  -> rom_addr runs 0,1,2,3; song_done after the 4th; rom_addr stays 3; no wrap.
- In PLAY, assert stop and note_change in the same cycle.
  -> IDLE, rom_addr=0, length=0, no FETCH, no song_done.
- play pulsed during PLAY at rom_addr=1.
  -> ignored; rom_addr stays 1 and length is unchanged.
- ROM[0]=0x9A (reserved code 9).
  -> treated as end marker: song_done, DONE, length never nonzero.
- MUSIC_SEQ_LOOP_EN defined, ROM[0]=0x11, ROM[1]=0x00.
  -> after note 0 ends, song_done pulses, rom_addr returns to 0, length=1 again, playing stays 1.
  -> rst mid-loop gives all outputs 0.
